// File: rtl/decode_stage_n_pkg.sv
// Shared types for the LoongArch32 N-wide decode stage.
// Class codes, opcode match constants, immediate kinds and the lane bundle.
package decode_stage_n_pkg;

    localparam int INST_W = 32;

    typedef enum logic [2:0] {
        CLS_ALU     = 3'd0,
        CLS_MULDIV  = 3'd1,
        CLS_LOAD    = 3'd2,
        CLS_STORE   = 3'd3,
        CLS_BRANCH  = 3'd4,
        CLS_CSR     = 3'd5,
        CLS_INVALID = 3'd7
    } cls_e;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_SI12,
        IMM_SI20,
        IMM_OFFS16,
        IMM_OFFS26
    } imm_e;

    localparam logic [5:0] OP6_LDST   = 6'b001010;
    localparam logic [5:0] OP6_JIRL   = 6'h13;
    localparam logic [5:0] OP6_B      = 6'h14;
    localparam logic [5:0] OP6_BL     = 6'h15;
    localparam logic [5:0] OP6_BRLAST = 6'h1B;
    localparam logic [7:0] OP8_CSR    = 8'h04;
    localparam logic [6:0] OP7_LU12I  = 7'b0001010;
    localparam logic [6:0] OP7_PCADDU = 7'b0001110;
    localparam logic [6:0] MD_LO      = 7'h38;
    localparam logic [6:0] MD_HI      = 7'h47;

    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rj;
        logic [4:0]  rk;
        logic        wen;
        cls_e        cls;
        logic [31:0] imm;
    } lane_t;

    function automatic logic [31:0] make_imm(imm_e t, logic [INST_W-1:0] inst);
        logic [31:0] r;
        r = '0;
        unique case (t)
            IMM_SI12:   r = {{20{inst[21]}}, inst[21:10]};
            IMM_SI20:   r = {inst[24:5], 12'b0};
            IMM_OFFS16: r = {{14{inst[25]}}, inst[25:10], 2'b00};
            IMM_OFFS26: r = {{4{inst[9]}}, inst[9:0], inst[25:10], 2'b00};
            default:    r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/decode_stage_n_lane.sv
// Single-lane combinational LoongArch32 field, class and immediate extraction.
// Used once per lane by decode_stage_n.
module decode_lane
    import decode_stage_n_pkg::*;
(
    input  logic [INST_W-1:0] inst_i,
    output lane_t             lane_o
);

    logic [5:0] op6;
    logic [3:0] op4;
    logic [6:0] op7;
    logic       is_3r;
    logic       is_si12;
    logic       is_u20;
    logic       is_ld;
    logic       is_st;
    logic       is_br;
    logic       is_csr;
    imm_e       imm_t;

    assign op6     = inst_i[31:26];
    assign op4     = inst_i[25:22];
    assign op7     = inst_i[21:15];
    assign is_3r   = (inst_i[31:22] == 10'd0);
    assign is_si12 = (op6 == 6'd0) && op4[3];
    assign is_u20  = (inst_i[31:25] == OP7_LU12I) ||
                     (inst_i[31:25] == OP7_PCADDU);
    assign is_ld   = (op6 == OP6_LDST) &&
                     (op4 inside {4'd0, 4'd1, 4'd2, 4'd8, 4'd9});
    assign is_st   = (op6 == OP6_LDST) &&
                     (op4 inside {4'd4, 4'd5, 4'd6});
    assign is_br   = (op6 >= OP6_JIRL) && (op6 <= OP6_BRLAST);
    assign is_csr  = (inst_i[31:24] == OP8_CSR);

    // Classify the instruction and pick register routing and immediate kind
    always_comb begin
        lane_o     = '0;
        lane_o.rd  = inst_i[4:0];
        lane_o.rj  = inst_i[9:5];
        lane_o.rk  = inst_i[14:10];
        lane_o.cls = CLS_INVALID;
        imm_t      = IMM_NONE;
        unique case (1'b1)
            is_3r: begin
                lane_o.cls = (op7 >= MD_LO && op7 <= MD_HI) ? CLS_MULDIV
                                                             : CLS_ALU;
                lane_o.wen = 1'b1;
            end
            is_si12: begin
                lane_o.cls = CLS_ALU;
                lane_o.wen = 1'b1;
                imm_t      = IMM_SI12;
            end
            is_u20: begin
                lane_o.cls = CLS_ALU;
                lane_o.wen = 1'b1;
                imm_t      = IMM_SI20;
            end
            is_ld: begin
                lane_o.cls = CLS_LOAD;
                lane_o.wen = 1'b1;
                imm_t      = IMM_SI12;
            end
            is_st: begin
                lane_o.cls = CLS_STORE;
                lane_o.rk  = inst_i[4:0];
                imm_t      = IMM_SI12;
            end
            is_csr: begin
                lane_o.cls = CLS_CSR;
                lane_o.wen = 1'b1;
            end
            is_br: begin
                lane_o.cls = CLS_BRANCH;
                if (op6 == OP6_JIRL) begin
                    lane_o.wen = 1'b1;
                    imm_t      = IMM_OFFS16;
                end else if (op6 == OP6_B) begin
                    imm_t = IMM_OFFS26;
                end else if (op6 == OP6_BL) begin
                    lane_o.rd  = 5'd1;
                    lane_o.wen = 1'b1;
                    imm_t      = IMM_OFFS26;
                end else begin
                    lane_o.rk = inst_i[4:0];
                    imm_t     = IMM_OFFS16;
                end
            end
            default: ;
        endcase
        if (lane_o.rd == 5'd0) lane_o.wen = 1'b0;
        lane_o.imm = make_imm(imm_t, inst_i);
    end

endmodule

// File: rtl/decode_stage_n.sv
// N-wide LoongArch32 decode stage: one output register with valid/ready.
// Optional DECODE_SKID_EN adds a one-bundle skid register and registered InReady.
module decode_stage_n
    import decode_stage_n_pkg::*;
#(
    parameter int DECODE_WIDTH = 4,
    parameter int PC_W         = 32
) (
    input  logic                           Clk,
    input  logic                           Rest,
    input  logic                           InFlush,
    input  logic                           InValid,
    output logic                           InReady,
    input  logic [PC_W-1:0]                InPc,
    input  logic [INST_W*DECODE_WIDTH-1:0] InInst,
    input  logic [DECODE_WIDTH-1:0]        InLaneMask,
    output logic                           OutValid,
    input  logic                           OutReady,
    output logic [DECODE_WIDTH-1:0]        OutLaneMask,
    output logic [PC_W*DECODE_WIDTH-1:0]   OutPc,
    output logic [5*DECODE_WIDTH-1:0]      OutRd,
    output logic [5*DECODE_WIDTH-1:0]      OutRj,
    output logic [5*DECODE_WIDTH-1:0]      OutRk,
    output logic [DECODE_WIDTH-1:0]        OutWen,
    output logic [3*DECODE_WIDTH-1:0]      OutClass,
    output logic [32*DECODE_WIDTH-1:0]     OutImm
);

    localparam int W = DECODE_WIDTH;

    lane_t [W-1:0]            dec_lane;
    logic  [W-1:0][PC_W-1:0]  dec_pc;
    lane_t [W-1:0]            pipe_lane_q, pipe_lane_d;
    logic  [W-1:0][PC_W-1:0]  pipe_pc_q, pipe_pc_d;
    logic  [W-1:0]            pipe_mask_q, pipe_mask_d;
    logic                     pipe_vld_q, pipe_vld_d;
    logic                     accept;

    for (genvar g = 0; g < W; g++) begin : g_lane
        lane_t raw;
        decode_lane u_lane (
            .inst_i (InInst[INST_W*g +: INST_W]),
            .lane_o (raw)
        );
        assign dec_lane[g] = InLaneMask[g] ? raw : lane_t'(0);
        assign dec_pc[g]   = InLaneMask[g] ? InPc + PC_W'(4 * g) : '0;

        assign OutPc[PC_W*g +: PC_W] = pipe_pc_q[g];
        assign OutRd[5*g +: 5]       = pipe_lane_q[g].rd;
        assign OutRj[5*g +: 5]       = pipe_lane_q[g].rj;
        assign OutRk[5*g +: 5]       = pipe_lane_q[g].rk;
        assign OutWen[g]             = pipe_lane_q[g].wen;
        assign OutClass[3*g +: 3]    = pipe_lane_q[g].cls;
        assign OutImm[32*g +: 32]    = pipe_lane_q[g].imm;
    end

    assign OutValid    = pipe_vld_q;
    assign OutLaneMask = pipe_mask_q;

`ifdef DECODE_SKID_EN
    lane_t [W-1:0]            skid_lane_q, skid_lane_d;
    logic  [W-1:0][PC_W-1:0]  skid_pc_q, skid_pc_d;
    logic  [W-1:0]            skid_mask_q, skid_mask_d;
    logic                     skid_vld_q, skid_vld_d;
    logic                     ready_q;

    assign InReady = ready_q && !InFlush;
    assign accept  = InValid && InReady;

    // Refill the output register from skid first so bundle order is kept
    always_comb begin
        pipe_vld_d  = pipe_vld_q;
        pipe_mask_d = pipe_mask_q;
        pipe_lane_d = pipe_lane_q;
        pipe_pc_d   = pipe_pc_q;
        skid_vld_d  = skid_vld_q;
        skid_mask_d = skid_mask_q;
        skid_lane_d = skid_lane_q;
        skid_pc_d   = skid_pc_q;
        if (InFlush) begin
            pipe_vld_d  = 1'b0;
            pipe_mask_d = '0;
            skid_vld_d  = 1'b0;
            skid_mask_d = '0;
        end else if (!pipe_vld_q || OutReady) begin
            if (skid_vld_q) begin
                pipe_vld_d  = 1'b1;
                pipe_mask_d = skid_mask_q;
                pipe_lane_d = skid_lane_q;
                pipe_pc_d   = skid_pc_q;
                skid_vld_d  = 1'b0;
            end else if (accept) begin
                pipe_vld_d  = 1'b1;
                pipe_mask_d = InLaneMask;
                pipe_lane_d = dec_lane;
                pipe_pc_d   = dec_pc;
            end else begin
                pipe_vld_d = 1'b0;
            end
        end else if (accept) begin
            skid_vld_d  = 1'b1;
            skid_mask_d = InLaneMask;
            skid_lane_d = dec_lane;
            skid_pc_d   = dec_pc;
        end
    end

    // Skid storage and the registered ready it drives
    always_ff @(posedge Clk) begin
        if (Rest) begin
            skid_vld_q  <= 1'b0;
            skid_mask_q <= '0;
            skid_lane_q <= '0;
            skid_pc_q   <= '0;
            ready_q     <= 1'b1;
        end else begin
            skid_vld_q  <= skid_vld_d;
            skid_mask_q <= skid_mask_d;
            skid_lane_q <= skid_lane_d;
            skid_pc_q   <= skid_pc_d;
            ready_q     <= !skid_vld_d;
        end
    end
`else
    assign InReady = !InFlush && (!pipe_vld_q || OutReady);
    assign accept  = InValid && InReady;

    // Load on accept, drain on consume, flush beats accept
    always_comb begin
        pipe_vld_d  = pipe_vld_q;
        pipe_mask_d = pipe_mask_q;
        pipe_lane_d = pipe_lane_q;
        pipe_pc_d   = pipe_pc_q;
        if (InFlush) begin
            pipe_vld_d  = 1'b0;
            pipe_mask_d = '0;
        end else if (accept) begin
            pipe_vld_d  = 1'b1;
            pipe_mask_d = InLaneMask;
            pipe_lane_d = dec_lane;
            pipe_pc_d   = dec_pc;
        end else if (OutReady) begin
            pipe_vld_d = 1'b0;
        end
    end
`endif

    // Output pipeline register
    always_ff @(posedge Clk) begin
        if (Rest) begin
            pipe_vld_q  <= 1'b0;
            pipe_mask_q <= '0;
            pipe_lane_q <= '0;
            pipe_pc_q   <= '0;
        end else begin
            pipe_vld_q  <= pipe_vld_d;
            pipe_mask_q <= pipe_mask_d;
            pipe_lane_q <= pipe_lane_d;
            pipe_pc_q   <= pipe_pc_d;
        end
    end

endmodule

// File: tb/tb_decode_stage_n.sv
// Directed bench for decode_stage_n (base build, 4 lanes, 32-bit PC).
// Drives on negedge, checks on the following negedge.
module tb_decode_stage_n;

    logic         Clk;
    logic         Rest;
    logic         InFlush;
    logic         InValid;
    logic         InReady;
    logic [31:0]  InPc;
    logic [127:0] InInst;
    logic [3:0]   InLaneMask;
    logic         OutValid;
    logic         OutReady;
    logic [3:0]   OutLaneMask;
    logic [127:0] OutPc;
    logic [19:0]  OutRd;
    logic [19:0]  OutRj;
    logic [19:0]  OutRk;
    logic [3:0]   OutWen;
    logic [11:0]  OutClass;
    logic [127:0] OutImm;

    int total = 0;
    int bad   = 0;

    decode_stage_n #(.DECODE_WIDTH(4), .PC_W(32)) dut (
        .Clk         (Clk),
        .Rest        (Rest),
        .InFlush     (InFlush),
        .InValid     (InValid),
        .InReady     (InReady),
        .InPc        (InPc),
        .InInst      (InInst),
        .InLaneMask  (InLaneMask),
        .OutValid    (OutValid),
        .OutReady    (OutReady),
        .OutLaneMask (OutLaneMask),
        .OutPc       (OutPc),
        .OutRd       (OutRd),
        .OutRj       (OutRj),
        .OutRk       (OutRk),
        .OutWen      (OutWen),
        .OutClass    (OutClass),
        .OutImm      (OutImm)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic [127:0] inst,
                         input logic [3:0] mask);
        InValid    = 1'b1;
        InPc       = pc;
        InInst     = inst;
        InLaneMask = mask;
    endtask

    localparam logic [127:0] BUNDLE_A =
        {32'h5800216C, 32'h29804149, 32'h28BFF107, 32'h001018A4};
    localparam logic [127:0] BUNDLE_B =
        {32'h00240000, 32'h00238000, 32'h001C1062, 32'h142468A1};
    localparam logic [127:0] BUNDLE_C =
        {32'hFFFFFFFF, 32'h4FFFFC41, 32'h02BFFC05, 32'h04000001};
    localparam logic [11:0]  CLS_A = {3'd4, 3'd3, 3'd2, 3'd0};
    localparam logic [11:0]  CLS_B = {3'd0, 3'd1, 3'd1, 3'd0};
    localparam logic [127:0] PC_A  =
        {32'h1C00000C, 32'h1C000008, 32'h1C000004, 32'h1C000000};

    initial begin
        Rest       = 1'b1;
        InFlush    = 1'b0;
        InValid    = 1'b0;
        InPc       = '0;
        InInst     = '0;
        InLaneMask = '0;
        OutReady   = 1'b1;
        repeat (2) @(negedge Clk);
        Rest = 1'b0;
        #1;
        check("rst_valid", OutValid, 0);
        check("rst_mask", OutLaneMask, 0);
        check("rst_pc", OutPc, 0);
        check("rst_imm", OutImm, 0);
        check("rst_ready", InReady, 1);

        // add.w / ld.w / st.w / beq
        drive(32'h1C000000, BUNDLE_A, 4'b1111);
        @(negedge Clk);
        InValid = 1'b0;
        check("a_valid", OutValid, 1);
        check("a_mask", OutLaneMask, 4'b1111);
        check("a_class", OutClass, CLS_A);
        check("a_pc", OutPc, PC_A);
        check("a_wen", OutWen, 4'b0011);
        check("a_rd", OutRd, {5'd12, 5'd9, 5'd7, 5'd4});
        check("a_rj", OutRj, {5'd11, 5'd10, 5'd8, 5'd5});
        check("a_rk", OutRk, {5'd12, 5'd9, 5'h1C, 5'd6});
        check("a_imm", OutImm,
              {32'h20, 32'h10, 32'hFFFFFFFC, 32'h0});

        // bl in lane 0 only, garbage in lanes 1..3
        drive(32'h1C000010,
              {32'hDEADBEEF, 32'h28BFF107, 32'hFFFFFFFF, 32'h54040000},
              4'b0001);
        @(negedge Clk);
        InValid = 1'b0;
        check("bl_mask", OutLaneMask, 4'b0001);
        check("bl_rd", OutRd, {15'd0, 5'd1});
        check("bl_wen", OutWen, 4'b0001);
        check("bl_class", OutClass, {9'd0, 3'd4});
        check("bl_imm", OutImm, {96'd0, 32'h400});
        check("bl_pc", OutPc, {96'd0, 32'h1C000010});
        check("bl_rj", OutRj, 0);
        check("bl_rk", OutRk, 0);

        // lu12i, mul.w, 3R op 0x47 with rd=0, 3R op 0x48 with rd=0
        drive(32'h0, BUNDLE_B, 4'b1111);
        @(negedge Clk);
        InValid = 1'b0;
        check("b_class", OutClass, CLS_B);
        check("b_wen", OutWen, 4'b0011);
        check("b_imm", OutImm, {96'd0, 32'h12345000});

        // csr, addi.w -1, jirl -4, all-ones word; PC wraps
        drive(32'hFFFFFFFC, BUNDLE_C, 4'b1111);
        @(negedge Clk);
        InValid = 1'b0;
        check("c_class", OutClass, {3'd7, 3'd4, 3'd0, 3'd5});
        check("c_wen", OutWen, 4'b0111);
        check("c_imm", OutImm,
              {32'h0, 32'hFFFFFFFC, 32'hFFFFFFFF, 32'h0});
        check("c_pc", OutPc,
              {32'h8, 32'h4, 32'h0, 32'hFFFFFFFC});

        // back-pressure: A held for 3 cycles while B waits
        drive(32'h1C000000, BUNDLE_A, 4'b1111);
        @(negedge Clk);
        OutReady = 1'b0;
        drive(32'h0, BUNDLE_B, 4'b1111);
        #1;
        check("stall_rdy0", InReady, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            check("stall_valid", OutValid, 1);
            check("stall_class", OutClass, CLS_A);
            check("stall_pc", OutPc, PC_A);
            check("stall_rdy", InReady, 0);
        end
        OutReady = 1'b1;
        #1;
        check("unstall_rdy", InReady, 1);
        @(negedge Clk);
        InValid = 1'b0;
        check("b2_valid", OutValid, 1);
        check("b2_class", OutClass, CLS_B);

        // flush together with a would-be accept, output held
        OutReady = 1'b0;
        InFlush  = 1'b1;
        drive(32'h1C000000, BUNDLE_A, 4'b1111);
        #1;
        check("flush_rdy", InReady, 0);
        @(negedge Clk);
        InFlush  = 1'b0;
        InValid  = 1'b0;
        OutReady = 1'b1;
        check("flush_valid", OutValid, 0);
        check("flush_mask", OutLaneMask, 0);
        #1;
        check("post_flush_rdy", InReady, 1);
        @(negedge Clk);
        check("post_flush_valid", OutValid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
